// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// mult/div sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MULT_CYCLES_DEF = 4;
  localparam int         DIV_CYCLES_DEF  = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_muldiv_seq.sv
// Mult/div latency sequencer: tracks the in-flight operation and raises a
// one-cycle HI/LO write strobe exactly N cycles after the start.
module muldiv_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      md_start,
  input  logic      is_div,
  output md_state_e state,
  output logic      hilo_ld,
  output logic      busy
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hilo_ld_q, hilo_ld_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] load_val;

  assign load_val = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = load_val;
        end
      end
      BUSY: begin
        // A start request here is impossible by construction and is ignored.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (md_start) begin
          state_d = BUSY;
          cnt_d   = load_val;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    hilo_ld_d = (state_d == DONE);
    busy_d    = (state_d == BUSY) || (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hilo_ld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hilo_ld_q <= hilo_ld_d;
      busy_q    <= busy_d;
    end
  end

  assign state   = state_q;
  assign hilo_ld = hilo_ld_q;
  assign busy    = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline. Optional performance
// counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       ID_HiLoOp,
  input  logic       EX_MemRead,
  input  logic       EX_RegWrite,
  input  logic [4:0] EX_RegDstData,
  input  logic       EX_IsMult,
  input  logic       EX_IsDiv,
  input  logic       MEM_Redirect,
  output logic       PC_Ld,
  output logic       IFID_Ld,
  output logic       IFID_Clr,
  output logic       IDEX_Ld,
  output logic       IDEX_Clr,
  output logic       EXMEM_Ld,
  output logic       EXMEM_Clr,
  output logic       MulDiv_Busy,
  output logic       HiLo_Ld
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt
`endif
);

  md_state_e md_state;
  logic      md_start;
  logic      load_use;
  logic      hilo_stall;
  logic      stall;
  logic      rst_hold_q, rst_hold_d;

  // The EX instruction always advances, so a mult/div starts unless it is being flushed.
  assign md_start = (EX_IsMult | EX_IsDiv) & ~MEM_Redirect;

  assign load_use = EX_MemRead & EX_RegWrite & (EX_RegDstData != REG_ZERO) &
                    ((ID_UsesRs & (ID_Rs == EX_RegDstData)) |
                     (ID_UsesRt & (ID_Rt == EX_RegDstData)));

  assign hilo_stall = ID_HiLoOp & ((md_state == BUSY) | md_start);
  assign stall      = load_use | hilo_stall;

  muldiv_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_muldiv_seq (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .md_start (md_start),
    .is_div   (EX_IsDiv),
    .state    (md_state),
    .hilo_ld  (HiLo_Ld),
    .busy     (MulDiv_Busy)
  );

  // Keeps every stage cleared until the first clock edge after reset release.
  assign rst_hold_d = 1'b0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rst_hold_q <= 1'b1;
    else        rst_hold_q <= rst_hold_d;
  end

  always_comb begin
    PC_Ld     = 1'b1;
    IFID_Ld   = 1'b1;
    IFID_Clr  = 1'b0;
    IDEX_Ld   = 1'b1;
    IDEX_Clr  = 1'b0;
    EXMEM_Ld  = 1'b1;
    EXMEM_Clr = 1'b0;
    if (rst_hold_q) begin
      PC_Ld     = 1'b0;
      IFID_Ld   = 1'b0;
      IFID_Clr  = 1'b1;
      IDEX_Ld   = 1'b0;
      IDEX_Clr  = 1'b1;
      EXMEM_Ld  = 1'b0;
      EXMEM_Clr = 1'b1;
    end else if (MEM_Redirect) begin
      PC_Ld     = 1'b1;
      IFID_Clr  = 1'b1;
      IDEX_Clr  = 1'b1;
      EXMEM_Clr = 1'b1;
    end else if (stall) begin
      PC_Ld    = 1'b0;
      IFID_Ld  = 1'b0;
      IDEX_Clr = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !MEM_Redirect && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (MEM_Redirect && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all compared against a cycle-indexed reference model.
module tb_pipe_hazard_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 32;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_RegDstData = '0;
  logic       ID_UsesRs = 0, ID_UsesRt = 0, ID_HiLoOp = 0;
  logic       EX_MemRead = 0, EX_RegWrite = 0, EX_IsMult = 0, EX_IsDiv = 0;
  logic       MEM_Redirect = 0;
  logic       PC_Ld, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr, EXMEM_Ld, EXMEM_Clr;
  logic       MulDiv_Busy, HiLo_Ld;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] Stall_Cnt, Flush_Cnt;
  longint      stallExp = 0, flushExp = 0;
`endif

  pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_HiLoOp(ID_HiLoOp), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_RegDstData(EX_RegDstData), .EX_IsMult(EX_IsMult), .EX_IsDiv(EX_IsDiv),
    .MEM_Redirect(MEM_Redirect),
    .PC_Ld(PC_Ld), .IFID_Ld(IFID_Ld), .IFID_Clr(IFID_Clr), .IDEX_Ld(IDEX_Ld),
    .IDEX_Clr(IDEX_Clr), .EXMEM_Ld(EXMEM_Ld), .EXMEM_Clr(EXMEM_Clr),
    .MulDiv_Busy(MulDiv_Busy), .HiLo_Ld(HiLo_Ld)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
  );

  always #5 Clk = ~Clk;

  int       checkCount = 0;
  int       passCount = 0;
  // Model: cycle index, cycle at which the current mult/div writes HI/LO.
  int       cyc = 0;
  int       mdEnd = -1;
  bit       holdExp = 1'b1;
  int       hiloCycles[$];
  logic [6:0] obsCtrl;
  logic     obsBusy;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRs,
                               input logic usesRt, input logic hiLoOp, input logic memRead,
                               input logic regWrite, input logic [4:0] dst, input logic isMult,
                               input logic isDiv, input logic redirect);
    ID_Rs = rs; ID_Rt = rt; ID_UsesRs = usesRs; ID_UsesRt = usesRt; ID_HiLoOp = hiLoOp;
    EX_MemRead = memRead; EX_RegWrite = regWrite; EX_RegDstData = dst;
    EX_IsMult = isMult; EX_IsDiv = isDiv; MEM_Redirect = redirect;
  endtask

  task automatic applyIdle();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  // Called just after a rising edge with inputs driven; checks at the falling edge.
  task automatic stepCycle();
    logic mdStart, busyState, loadUse, stall;
    logic [6:0] expCtrl;
    @(negedge Clk);
    mdStart   = (EX_IsMult | EX_IsDiv) & ~MEM_Redirect;
    busyState = (cyc < mdEnd);
    loadUse   = EX_MemRead & EX_RegWrite & (EX_RegDstData != 5'd0) &
                ((ID_UsesRs & (ID_Rs == EX_RegDstData)) | (ID_UsesRt & (ID_Rt == EX_RegDstData)));
    stall     = loadUse | (ID_HiLoOp & (busyState | mdStart));
    // Order: PC_Ld, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr, EXMEM_Ld, EXMEM_Clr
    if (holdExp)           expCtrl = 7'b0010101;
    else if (MEM_Redirect) expCtrl = 7'b1111111;
    else if (stall)        expCtrl = 7'b0001110;
    else                   expCtrl = 7'b1101010;
    obsCtrl = {PC_Ld, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr, EXMEM_Ld, EXMEM_Clr};
    obsBusy = MulDiv_Busy;
    checkOutput("ctrl", {25'd0, obsCtrl}, {25'd0, expCtrl});
    checkOutput("busy", {31'd0, MulDiv_Busy}, {31'd0, (cyc <= mdEnd)});
    checkOutput("hilo", {31'd0, HiLo_Ld}, {31'd0, (cyc == mdEnd)});
    if (HiLo_Ld) hiloCycles.push_back(cyc);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("stall_cnt", Stall_Cnt, stallExp[31:0]);
    checkOutput("flush_cnt", Flush_Cnt, flushExp[31:0]);
`endif
    @(posedge Clk);
    holdExp = 1'b0;
    if (mdStart && !busyState) mdEnd = cyc + (EX_IsDiv ? DIV_N : MULT_N);
`ifdef HAZARD_PERF_CNT_EN
    if (stall && !MEM_Redirect && stallExp < 64'hFFFF_FFFF) stallExp++;
    if (MEM_Redirect && flushExp < 64'hFFFF_FFFF) flushExp++;
`endif
    cyc++;
    #1;
  endtask

  // Asserts reset just after an edge, checks the immediate effect, releases after the next edge.
  task automatic doReset();
    applyIdle();
    Rst_n = 1'b0;
    #1;
    checkOutput("rst_ctrl", {25'd0, PC_Ld, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr, EXMEM_Ld, EXMEM_Clr},
                32'h15);
    checkOutput("rst_busy", {31'd0, MulDiv_Busy}, 32'd0);
    checkOutput("rst_hilo", {31'd0, HiLo_Ld}, 32'd0);
    mdEnd   = -1;
    holdExp = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    stallExp = 0;
    flushExp = 0;
`endif
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    int t;
    int busyCount;
    logic [4:0] ifidVec;

    @(posedge Clk);
    #1;
    doReset();
    stepCycle();
    stepCycle();

    // Load-use on rs, then the same with $0 as destination.
    applyStimulus(5'd8, 5'd3, 1, 1, 0, 1, 1, 5'd8, 0, 0, 0);
    stepCycle();
    checkOutput("loaduse_pc", {31'd0, obsCtrl[6]}, 32'd0);
    checkOutput("loaduse_idex_clr", {31'd0, obsCtrl[2]}, 32'd1);
    applyStimulus(5'd0, 5'd3, 1, 1, 0, 1, 1, 5'd0, 0, 0, 0);
    stepCycle();
    checkOutput("zero_reg_pc", {31'd0, obsCtrl[6]}, 32'd1);
    applyStimulus(5'd4, 5'd9, 1, 1, 0, 1, 1, 5'd9, 0, 0, 0);
    stepCycle();
    checkOutput("loaduse_rt_ifid", {31'd0, obsCtrl[5]}, 32'd0);

    // Redirect wins over a simultaneous load-use.
    applyStimulus(5'd8, 5'd3, 1, 1, 0, 1, 1, 5'd8, 0, 0, 1);
    stepCycle();
    checkOutput("redirect_ctrl", {25'd0, obsCtrl}, 32'h7F);
    applyIdle();
    stepCycle();

    // Mult with an mflo waiting in ID.
    hiloCycles.delete();
    t = cyc;
    ifidVec = '0;
    applyStimulus(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1, 0, 0);
    stepCycle();
    ifidVec[0] = obsCtrl[5];
    applyStimulus(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      stepCycle();
      ifidVec[i] = obsCtrl[5];
    end
    applyIdle();
    stepCycle();
    checkOutput("mult_stall_window", {27'd0, ifidVec}, 32'h10);
    checkOutput("mult_hilo_count", hiloCycles.size(), 32'd1);
    if (hiloCycles.size() > 0) checkOutput("mult_hilo_at", hiloCycles[0] - t, MULT_N);

    // Back-to-back divides, second one issued in the DONE cycle.
    hiloCycles.delete();
    busyCount = 0;
    t = cyc;
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
    stepCycle();
    applyIdle();
    while (cyc < t + DIV_N) begin
      stepCycle();
      busyCount += int'(obsBusy);
    end
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
    stepCycle();
    busyCount += int'(obsBusy);
    applyIdle();
    while (cyc <= t + 2 * DIV_N) begin
      stepCycle();
      busyCount += int'(obsBusy);
    end
    stepCycle();
    checkOutput("div_hilo_count", hiloCycles.size(), 32'd2);
    checkOutput("div_busy_span", busyCount, 2 * DIV_N);
    if (hiloCycles.size() > 1) begin
      checkOutput("div_hilo_first", hiloCycles[0] - t, DIV_N);
      checkOutput("div_hilo_second", hiloCycles[1] - t, 2 * DIV_N);
    end

    // Reset while a divide is in flight.
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
    stepCycle();
    applyIdle();
    for (int i = 0; i < 5; i++) stepCycle();
    doReset();
    stepCycle();
    stepCycle();
    checkOutput("post_rst_ctrl", {25'd0, obsCtrl}, 32'h6A);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 11) == 0), ($urandom_range(0, 23) == 0),
                    ($urandom_range(0, 5) == 0));
      stepCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
